// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types for the UART TX arbiter.
// State encoding and index-width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_LAUNCH    = 2'b01,
        ST_WAIT_DONE = 2'b11
    } arb_state_t;

    // 2'b10 is the spare encoding; it decodes back to ST_IDLE.
    localparam logic [1:0] ST_SPARE = 2'b10;

    function automatic int gid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: round-robin pick of the next requester.
// Scans last_grant+1 upward, wrapping, ending at last_grant.
module rr_select
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GID_W = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [GID_W-1:0] last_grant,
    output logic [GID_W-1:0] sel,
    output logic             any_req
);

    logic [GID_W-1:0] idx;

    // first asserted request after last_grant wins
    always_comb begin
        sel     = last_grant;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = GID_W'((int'(last_grant) + k) % N_REQ);
            if (!any_req && req_valid[idx]) begin
                sel     = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX core among N_REQ producers.
// Round-robin grant, registered launch/wait FSM with timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 200000,
    localparam int GID_W      = gid_w(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic [GID_W-1:0]        grant_id,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int CNT_W = gid_w(TIMEOUT_CYC);
    localparam logic [GID_W-1:0] GID_LAST = GID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  ready_q, ready_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [GID_W-1:0]  gid_q, gid_d;
    logic [GID_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic [GID_W-1:0]  sel;
    logic              any_req;

    rr_select #(
        .N_REQ (N_REQ),
        .GID_W (GID_W)
    ) u_rr (
        .req_valid  (req_valid),
        .last_grant (last_q),
        .sel        (sel),
        .any_req    (any_req)
    );

    // state and every output pulse/field are registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ready_q <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            gid_q   <= GID_LAST;
            last_q  <= GID_LAST;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            start_q <= start_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // next state; pulses default low, fields hold
    always_comb begin
        state_d = ST_IDLE;
        ready_d = '0;
        start_d = 1'b0;
        data_d  = data_q;
        gid_d   = gid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req && !tx_busy) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (GID_W'(i) == sel) begin
                            ready_d[i] = 1'b1;
                            data_d = req_data[i*DATA_W +: DATA_W];
                        end
                    end
                    gid_d   = sel;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    last_d = gid_q;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d  = 1'b1;
                    last_d = gid_q;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_WAIT_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready   = ready_q;
    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign grant_id    = gid_q;
    assign timeout_err = tmo_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
